// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants and FSM encodings for the FFT transmit path.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int          N_POINTS    = 2048;
    localparam int          LOG2N       = 11;
    localparam int          DATA_W      = 16;
    localparam logic [15:0] FFT_CFG_FWD = 16'h0001;

    typedef enum logic [1:0] {
        S_CFG    = 2'd0,
        S_IDLE   = 2'd1,
        S_STREAM = 2'd2
    } fft_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_pingpong_ram
// Purpose  : Two-bank sample store, one write port, one registered read port.
// Revision : 1.0
// ============================================================================
module fft_pingpong_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // Address MSB selects the bank; no reset so the array maps onto block RAM.
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_feeder
// Purpose  : Frames the sample stream into ping-pong banks and streams each
//            full bank into the FFT AXI-stream input after the config word.
// Revision : 1.0
// ============================================================================
module fft_frame_feeder #(
    parameter int          N_POINTS = fft_pkg::N_POINTS,
    parameter int          LOG2N    = fft_pkg::LOG2N,
    parameter int          DATA_W   = fft_pkg::DATA_W,
    parameter logic [15:0] CFG_WORD = fft_pkg::FFT_CFG_FWD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [15:0]       m_axis_config_tdata,
    output logic              m_axis_config_tvalid,
    input  logic              m_axis_config_tready,
    output logic [31:0]       m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic              m_axis_data_tlast,
    output logic [LOG2N-1:0]  m_axis_data_tuser,
    output logic              overflow,
    output logic [15:0]       frame_count
);
    import fft_pkg::*;

    localparam logic [LOG2N-1:0] c_last_idx = LOG2N'(N_POINTS - 1);

    fft_state_t        r_state, w_state_nxt;
    logic              r_cfg_valid;
    logic              r_wr_bank;
    logic [LOG2N-1:0]  r_wr_idx;
    logic [1:0]        r_full, w_full_nxt;
    logic              r_overflow;
    logic [15:0]       r_frame_count;
    logic [LOG2N:0]    r_rd_idx;
    logic              r_rd_pend;
    logic [LOG2N-1:0]  r_rd_pend_idx;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] r_sk_data [2];
    logic [LOG2N-1:0]  r_sk_idx  [2];
    logic [1:0]        r_sk_cnt;

    logic       w_rd_bank, w_wr_accept, w_wr_last, w_pop, w_rd_done;
    logic       w_swap, w_rd_issue, w_start;
    logic [2:0] w_occ;

    // The bank not being written is always the one being read.
    assign w_rd_bank   = ~r_wr_bank;
    assign w_wr_accept = sample_valid && !r_full[r_wr_bank];
    assign w_wr_last   = w_wr_accept && (r_wr_idx == c_last_idx);
    assign w_pop       = m_axis_data_tvalid && m_axis_data_tready;
    assign w_rd_done   = w_pop && m_axis_data_tlast;
    assign w_swap      = w_full_nxt[r_wr_bank] && !w_full_nxt[w_rd_bank];
    assign w_start     = (r_state == S_IDLE) && (w_state_nxt == S_STREAM);
    assign w_occ       = 3'(r_sk_cnt) + 3'(r_rd_pend) - 3'(w_pop);

    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done) w_full_nxt[w_rd_bank] = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        case (r_state)
            S_CFG:    if (r_cfg_valid && m_axis_config_tready) w_state_nxt = S_IDLE;
            S_IDLE:   if (r_full[w_rd_bank]) w_state_nxt = S_STREAM;
            S_STREAM: begin
                // Prefetch only while the skid buffer is guaranteed room next cycle.
                w_rd_issue = !r_rd_idx[LOG2N] && (w_occ <= 3'd1);
                if (w_rd_done) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_CFG;
            r_cfg_valid   <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_full        <= 2'b00;
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
            r_rd_idx      <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_pend_idx <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cfg_valid   <= (w_state_nxt == S_CFG);
            r_full        <= w_full_nxt;
            if (w_swap) begin
                r_wr_bank <= w_rd_bank;
                r_wr_idx  <= '0;
            end else if (w_wr_accept) begin
                r_wr_idx  <= r_wr_idx + 1'b1;
            end
            if (sample_valid && !w_wr_accept) r_overflow <= 1'b1;
            if (w_rd_done) r_frame_count <= r_frame_count + 16'd1;
            if (w_start) begin
                r_rd_idx <= '0;
            end else if (w_rd_issue) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            r_rd_pend     <= w_rd_issue;
            r_rd_pend_idx <= r_rd_idx[LOG2N-1:0];
        end
    end

    // Two-entry skid buffer; entry 0 is the head presented on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sk_cnt     <= 2'd0;
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_idx[0]  <= '0;
            r_sk_idx[1]  <= '0;
        end else begin
            case ({w_pop, r_rd_pend})
                2'b10: begin
                    r_sk_data[0] <= r_sk_data[1];
                    r_sk_idx[0]  <= r_sk_idx[1];
                    r_sk_cnt     <= r_sk_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_sk_cnt == 2'd0) begin
                        r_sk_data[0] <= w_ram_rdata;
                        r_sk_idx[0]  <= r_rd_pend_idx;
                    end else begin
                        r_sk_data[1] <= w_ram_rdata;
                        r_sk_idx[1]  <= r_rd_pend_idx;
                    end
                    r_sk_cnt <= r_sk_cnt + 2'd1;
                end
                2'b11: begin
                    if (r_sk_cnt == 2'd2) begin
                        r_sk_data[0] <= r_sk_data[1];
                        r_sk_idx[0]  <= r_sk_idx[1];
                        r_sk_data[1] <= w_ram_rdata;
                        r_sk_idx[1]  <= r_rd_pend_idx;
                    end else begin
                        r_sk_data[0] <= w_ram_rdata;
                        r_sk_idx[0]  <= r_rd_pend_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    fft_pingpong_ram #(
        .ADDR_W (LOG2N + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr ({r_wr_bank, r_wr_idx}),
        .i_wr_data (sample_in),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr ({w_rd_bank, r_rd_idx[LOG2N-1:0]}),
        .o_rd_data (w_ram_rdata)
    );

    assign m_axis_config_tdata  = CFG_WORD;
    assign m_axis_config_tvalid = r_cfg_valid;
    assign m_axis_data_tvalid   = (r_sk_cnt != 2'd0);
    assign m_axis_data_tdata    = {16'h0000, 16'($signed(r_sk_data[0]))};
    assign m_axis_data_tuser    = r_sk_idx[0];
    assign m_axis_data_tlast    = (r_sk_idx[0] == c_last_idx);
    assign overflow             = r_overflow;
    assign frame_count          = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_feeder
// Purpose  : Directed self-checking bench for fft_frame_feeder.
// Revision : 1.0
// ============================================================================
module tb_fft_frame_feeder;

    localparam int N = 2048;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic [15:0] sample_in    = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready   = 1'b1;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready       = 1'b0;
    logic        tlast;
    logic [10:0] tuser;
    logic        overflow;
    logic [15:0] frame_count;

    int          checks    = 0;
    int          failures  = 0;
    int          frames_rx = 0;
    int          beat_idx  = 0;
    int          rdy_mode  = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    logic        prev_hold = 1'b0;
    logic [43:0] prev_bits = '0;

    always #5 clk = ~clk;

    fft_frame_feeder dut (
        .clk                  (clk),
        .reset                (reset),
        .sample_in            (sample_in),
        .sample_valid         (sample_valid),
        .m_axis_config_tdata  (cfg_tdata),
        .m_axis_config_tvalid (cfg_tvalid),
        .m_axis_config_tready (cfg_tready),
        .m_axis_data_tdata    (tdata),
        .m_axis_data_tvalid   (tvalid),
        .m_axis_data_tready   (tready),
        .m_axis_data_tlast    (tlast),
        .m_axis_data_tuser    (tuser),
        .overflow             (overflow),
        .frame_count          (frame_count)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] v, input bit keep);
        sample_valid = 1'b1;
        sample_in    = v;
        if (keep) exp_q.push_back(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_rx < target && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check_value("frames_rx", 64'(frames_rx), 64'(target));
    endtask

    task automatic count_cfg(input int window, input string tag);
        int seen = 0;
        for (int k = 0; k < window; k++) begin
            if (cfg_tvalid) begin
                seen++;
                check_value({tag, "_tdata"}, 64'(cfg_tdata), 64'h0001);
            end
            tick();
        end
        check_value({tag, "_cycles"}, 64'(seen), 64'd1);
    endtask

    // Sink ready policy: 0 always ready, 1 random 50%, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    end

    // Beat scoreboard; beat index is tracked independently of the DUT's tlast.
    always @(negedge clk) begin
        if (reset) begin
            beat_idx  = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check_value("hold", 64'({tvalid, tlast, tuser, tdata}), 64'({1'b1, prev_bits}));
            if (tvalid && tready) begin
                check_value("beat_avail", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check_value("beat", 64'({tlast, tuser, tdata}),
                                64'({beat_idx == N - 1, 11'(beat_idx), 16'h0000, mon_exp}));
                end
                if (beat_idx == N - 1) begin
                    beat_idx = 0;
                    frames_rx++;
                end else begin
                    beat_idx++;
                end
            end
            prev_hold = tvalid && !tready;
            prev_bits = {tlast, tuser, tdata};
        end
    end

    initial begin
        int n;
        int data_seen;

        // 1: reset values and single config handshake
        rdy_mode = 0;
        repeat (3) tick();
        check_value("rst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        check_value("rst_cfg_tdata", 64'(cfg_tdata), 64'h0001);
        check_value("rst_tvalid", 64'(tvalid), 64'd0);
        check_value("rst_tdata", 64'(tdata), 64'd0);
        check_value("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
        check_value("rst_overflow", 64'(overflow), 64'd0);
        check_value("rst_frame_count", 64'(frame_count), 64'd0);
        reset = 1'b0;
        count_cfg(10, "cfg");

        // 2: ramp at one sample per cycle, sink always ready
        for (int i = 0; i < N; i++) drive(16'(i), 1'b1);
        wait_frames(1, 3000);
        check_value("t2_frame_count", 64'(frame_count), 64'd1);
        check_value("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: second frame under random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < N; i++) drive(16'h1000 + 16'(i), 1'b1);
        wait_frames(2, 8000);
        rdy_mode = 0;
        check_value("t3_frame_count", 64'(frame_count), 64'd2);
        check_value("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: sink stalled, both banks fill and sample 4096 onward is dropped
        rdy_mode = 2;
        for (int i = 0; i < 5000; i++) begin
            drive(16'h4000 + 16'(i), i < 2 * N);
            if (i == 2 * N - 1) check_value("t4_ovf_before", 64'(overflow), 64'd0);
            if (i == 2 * N)     check_value("t4_ovf_at_4096", 64'(overflow), 64'd1);
        end
        rdy_mode = 0;
        wait_frames(4, 6000);
        check_value("t4_frame_count", 64'(frame_count), 64'd4);
        check_value("t4_ovf_sticky", 64'(overflow), 64'd1);
        check_value("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        reset = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        reset = 1'b0;
        check_value("rst2_overflow", 64'(overflow), 64'd0);
        check_value("rst2_frame_count", 64'(frame_count), 64'd0);
        count_cfg(6, "cfg2");

        // 5: ten frames of streaming input; the stream leaves one idle slot in
        // four because each frame read needs a few cycles beyond its 2048 beats.
        for (int k = 0; k < 10 * N; k++) begin
            drive(16'(k * 3 + 5), 1'b1);
            if (k % 3 == 2) tick();
        end
        wait_frames(14, 4000);
        check_value("t5_frame_count", 64'(frame_count), 64'd10);
        check_value("t5_overflow", 64'(overflow), 64'd0);
        check_value("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset at beat 1000, config re-sent, next frame restarts at index 0
        for (int i = 0; i < N; i++) drive(16'h6000 + 16'(i), 1'b1);
        n = 0;
        while (beat_idx < 1000 && n < 3000) begin
            tick();
            n++;
        end
        check_value("t6_reach_beat", 64'(beat_idx), 64'd1000);
        reset      = 1'b1;
        cfg_tready = 1'b0;
        tick();
        check_value("t6_tvalid_drop", 64'(tvalid), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        data_seen = 0;
        for (int i = 0; i < N; i++) begin
            drive(16'h7000 + 16'(i), 1'b1);
            if (tvalid) data_seen++;
        end
        repeat (50) begin
            tick();
            if (tvalid) data_seen++;
        end
        check_value("t6_no_data_before_cfg", 64'(data_seen), 64'd0);
        check_value("t6_cfg_waiting", 64'(cfg_tvalid), 64'd1);
        cfg_tready = 1'b1;
        count_cfg(5, "cfg3");
        wait_frames(15, 3000);
        check_value("t6_frame_count", 64'(frame_count), 64'd1);
        check_value("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
